// File: rtl/operand_fetch_pipe.sv
// Operand fetch stage: resolves A/B sources through EX/WB bypass, detects
// load-use hazards, and registers the decoded instruction toward EX.
module operand_fetch_pipe #(
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 5,
    parameter int IMM_W      = 5,
    parameter int OP_W       = 5,
    parameter int PC_W       = 16,
    parameter int IMM_SIGNED = 0,
    parameter int ZERO_REG   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_addr_mode,
    input  logic [IDX_W-1:0]  in_idx_a,
    input  logic [IDX_W-1:0]  in_idx_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [3:0]        in_branch_cond,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_has_wb,
    output logic [IDX_W-1:0]  rd_idx_a,
    output logic [IDX_W-1:0]  rd_idx_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    input  logic              ex_fwd_valid,
    input  logic [IDX_W-1:0]  ex_fwd_idx,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              ex_busy_valid,
    input  logic [IDX_W-1:0]  ex_busy_idx,
    input  logic              wb_fwd_valid,
    input  logic [IDX_W-1:0]  wb_fwd_idx,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_operand_a,
    output logic [DATA_W-1:0] out_operand_b,
    output logic [3:0]        out_branch_cond,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_has_wb,
    output logic [IDX_W-1:0]  out_dst_idx
);

    logic [IDX_W-1:0]  src_idx    [2];
    logic [DATA_W-1:0] src_rd     [2];
    logic              src_used   [2];
    logic              src_zero   [2];
    logic              src_ex_hit [2];
    logic              src_wb_hit [2];
    logic              src_haz    [2];
    logic [DATA_W-1:0] src_val    [2];

    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] operand_b_next;

    logic              out_valid_reg;
    logic [OP_W-1:0]   out_op_reg;
    logic [DATA_W-1:0] out_operand_a_reg;
    logic [DATA_W-1:0] out_operand_b_reg;
    logic [3:0]        out_branch_cond_reg;
    logic [PC_W-1:0]   out_pc_reg;
    logic              out_has_wb_reg;
    logic [IDX_W-1:0]  out_dst_idx_reg;

    assign rd_idx_a = in_idx_a;
    assign rd_idx_b = in_idx_b;

    assign src_idx[0]  = in_idx_a;
    assign src_idx[1]  = in_idx_b;
    assign src_rd[0]   = rd_data_a;
    assign src_rd[1]   = rd_data_b;
    assign src_used[0] = 1'b1;
    assign src_used[1] = ~in_addr_mode;

    // EX bypass beats WB bypass: EX holds the younger writer of the register.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_zero[gi]   = (ZERO_REG != 0) && (src_idx[gi] == '0);
            assign src_ex_hit[gi] = ex_fwd_valid && (ex_fwd_idx == src_idx[gi]);
            assign src_wb_hit[gi] = wb_fwd_valid && (wb_fwd_idx == src_idx[gi]);
            assign src_val[gi]    = src_zero[gi]   ? '0          :
                                    src_ex_hit[gi] ? ex_fwd_data :
                                    src_wb_hit[gi] ? wb_fwd_data :
                                                     src_rd[gi];
            assign src_haz[gi]    = src_used[gi] && !src_zero[gi] && ex_busy_valid &&
                                    (ex_busy_idx == src_idx[gi]) && !src_ex_hit[gi];
        end
    endgenerate

    generate
        if (IMM_SIGNED != 0) begin : g_imm_sext
            assign imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        end else begin : g_imm_zext
            assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
        end
    endgenerate

    assign operand_b_next = in_addr_mode ? imm_ext : src_val[1];
    assign hazard         = in_valid && (src_haz[0] || src_haz[1]);
    assign in_ready       = (~out_valid_reg | out_ready) & ~hazard & ~flush & ~reset;
    assign accept         = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg       <= 1'b0;
            out_op_reg          <= '0;
            out_operand_a_reg   <= '0;
            out_operand_b_reg   <= '0;
            out_branch_cond_reg <= '0;
            out_pc_reg          <= '0;
            out_has_wb_reg      <= 1'b0;
            out_dst_idx_reg     <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg       <= 1'b1;
            out_op_reg          <= in_op;
            out_operand_a_reg   <= src_val[0];
            out_operand_b_reg   <= operand_b_next;
            out_branch_cond_reg <= in_branch_cond;
            out_pc_reg          <= in_pc;
            out_has_wb_reg      <= in_has_wb;
            out_dst_idx_reg     <= in_idx_a;
        end else if (out_ready) begin
            // Consumed with nothing new (idle or hazard bubble); data fields hold.
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_op          = out_op_reg;
    assign out_operand_a   = out_operand_a_reg;
    assign out_operand_b   = out_operand_b_reg;
    assign out_branch_cond = out_branch_cond_reg;
    assign out_pc          = out_pc_reg;
    assign out_has_wb      = out_has_wb_reg;
    assign out_dst_idx     = out_dst_idx_reg;

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Directed bench for operand_fetch_pipe; a second instance with sign-extended
// immediates shares all inputs.
module tb_operand_fetch_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_op;
    logic        in_addr_mode;
    logic [4:0]  in_idx_a, in_idx_b;
    logic [4:0]  in_imm;
    logic [3:0]  in_branch_cond;
    logic [15:0] in_pc;
    logic        in_has_wb;
    logic [15:0] rd_data_a, rd_data_b;
    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_idx;
    logic [15:0] ex_fwd_data;
    logic        ex_busy_valid;
    logic [4:0]  ex_busy_idx;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_idx;
    logic [15:0] wb_fwd_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready, in_ready_s;
    logic [4:0]  rd_idx_a, rd_idx_b, rd_idx_a_s, rd_idx_b_s;
    logic        out_valid, out_valid_s;
    logic [4:0]  out_op, out_op_s;
    logic [15:0] out_operand_a, out_operand_b, out_operand_a_s, out_operand_b_s;
    logic [3:0]  out_branch_cond, out_branch_cond_s;
    logic [15:0] out_pc, out_pc_s;
    logic        out_has_wb, out_has_wb_s;
    logic [4:0]  out_dst_idx, out_dst_idx_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_fetch_pipe #(.IMM_SIGNED(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr_mode(in_addr_mode), .in_idx_a(in_idx_a), .in_idx_b(in_idx_b),
        .in_imm(in_imm), .in_branch_cond(in_branch_cond), .in_pc(in_pc), .in_has_wb(in_has_wb),
        .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
        .ex_busy_valid(ex_busy_valid), .ex_busy_idx(ex_busy_idx),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
        .out_branch_cond(out_branch_cond), .out_pc(out_pc), .out_has_wb(out_has_wb),
        .out_dst_idx(out_dst_idx)
    );

    operand_fetch_pipe #(.IMM_SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_op(in_op), .in_addr_mode(in_addr_mode), .in_idx_a(in_idx_a), .in_idx_b(in_idx_b),
        .in_imm(in_imm), .in_branch_cond(in_branch_cond), .in_pc(in_pc), .in_has_wb(in_has_wb),
        .rd_idx_a(rd_idx_a_s), .rd_idx_b(rd_idx_b_s), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
        .ex_busy_valid(ex_busy_valid), .ex_busy_idx(ex_busy_idx),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid_s), .out_ready(out_ready), .out_op(out_op_s),
        .out_operand_a(out_operand_a_s), .out_operand_b(out_operand_b_s),
        .out_branch_cond(out_branch_cond_s), .out_pc(out_pc_s), .out_has_wb(out_has_wb_s),
        .out_dst_idx(out_dst_idx_s)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; combinational checks follow after a settle delay.
    task automatic drive(input logic [4:0] op, input logic mode, input logic [4:0] ia,
                         input logic [4:0] ib, input logic [4:0] imm,
                         input logic [15:0] ra, input logic [15:0] rb);
        in_valid       = 1'b1;
        in_op          = op;
        in_addr_mode   = mode;
        in_idx_a       = ia;
        in_idx_b       = ib;
        in_imm         = imm;
        rd_data_a      = ra;
        rd_data_b      = rb;
        in_branch_cond = 4'h3;
        in_pc          = 16'h0100 + {11'd0, op};
        in_has_wb      = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_addr_mode = 1'b0;
        in_idx_a = '0; in_idx_b = '0; in_imm = '0; in_branch_cond = '0; in_pc = '0;
        in_has_wb = 1'b0; rd_data_a = '0; rd_data_b = '0;
        ex_fwd_valid = 1'b0; ex_fwd_idx = '0; ex_fwd_data = '0;
        ex_busy_valid = 1'b0; ex_busy_idx = '0;
        wb_fwd_valid = 1'b0; wb_fwd_idx = '0; wb_fwd_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        drive(5'd9, 1'b0, 5'd1, 5'd2, 5'd0, 16'h1234, 16'h5678);
        check("rst_in_ready", in_ready, 0);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_operand_a", out_operand_a, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Direct ADD
        drive(5'd1, 1'b0, 5'd3, 5'd4, 5'd0, 16'h0010, 16'h0020);
        check("rd_idx_a", rd_idx_a, 3);
        check("rd_idx_b", rd_idx_b, 4);
        check("add_in_ready", in_ready, 1);
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_a", out_operand_a, 16'h0010);
        check("add_b", out_operand_b, 16'h0020);
        check("add_dst", out_dst_idx, 3);
        check("add_op", out_op, 1);
        check("add_pc", out_pc, 16'h0101);
        check("add_cond", out_branch_cond, 4'h3);
        check("add_has_wb", out_has_wb, 1);

        // Immediate 5'b11111, both extension modes
        drive(5'd2, 1'b1, 5'd1, 5'd4, 5'h1f, 16'h0005, 16'hBEEF);
        tick();
        check("imm_zext_b", out_operand_b, 16'h001F);
        check("imm_sext_b", out_operand_b_s, 16'hFFFF);
        check("imm_a", out_operand_a, 16'h0005);

        // Bypass priority on A
        ex_fwd_valid = 1'b1; ex_fwd_idx = 5'd7; ex_fwd_data = 16'h1111;
        wb_fwd_valid = 1'b1; wb_fwd_idx = 5'd7; wb_fwd_data = 16'h2222;
        drive(5'd3, 1'b1, 5'd7, 5'd0, 5'd0, 16'h3333, 16'h0);
        tick();
        check("fwd_ex_wins", out_operand_a, 16'h1111);
        ex_fwd_valid = 1'b0;
        drive(5'd3, 1'b1, 5'd7, 5'd0, 5'd0, 16'h3333, 16'h0);
        tick();
        check("fwd_wb_only", out_operand_a, 16'h2222);
        ex_fwd_valid = 1'b1; ex_fwd_idx = 5'd0; wb_fwd_idx = 5'd0;
        drive(5'd3, 1'b1, 5'd0, 5'd0, 5'd0, 16'h4444, 16'h0);
        tick();
        check("zero_reg_a", out_operand_a, 0);
        ex_fwd_valid = 1'b0; wb_fwd_idx = 5'd9; wb_fwd_data = 16'h9999;
        drive(5'd4, 1'b0, 5'd2, 5'd9, 5'd0, 16'h0002, 16'h7777);
        tick();
        check("fwd_wb_b", out_operand_b, 16'h9999);
        check("no_fwd_a", out_operand_a, 16'h0002);
        wb_fwd_valid = 1'b0;

        // Load-use hazard on B
        ex_busy_valid = 1'b1; ex_busy_idx = 5'd6;
        drive(5'd5, 1'b0, 5'd2, 5'd6, 5'd0, 16'h00AB, 16'h00CD);
        check("haz_in_ready", in_ready, 0);
        tick();
        check("haz_bubble", out_valid, 0);
        check("haz_a_hold", out_operand_a, 16'h0002);
        ex_fwd_valid = 1'b1; ex_fwd_idx = 5'd6; ex_fwd_data = 16'h0606;
        #1;
        check("haz_fwd_clears", in_ready, 1);
        ex_fwd_valid = 1'b0;
        drive(5'd5, 1'b1, 5'd2, 5'd6, 5'd1, 16'h00AB, 16'h00CD);
        check("imm_no_stall", in_ready, 1);
        tick();
        check("imm_no_stall_valid", out_valid, 1);
        check("imm_no_stall_a", out_operand_a, 16'h00AB);
        ex_busy_valid = 1'b0;

        // Back-pressure: X accepted, then Y held for 3 cycles
        drive(5'd10, 1'b0, 5'd10, 5'd1, 5'd0, 16'hAAAA, 16'h0101);
        tick();
        out_ready = 1'b0;
        drive(5'd11, 1'b0, 5'd11, 5'd1, 5'd0, 16'hBBBB, 16'h0202);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", in_ready, 0);
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_a", out_operand_a, 16'hAAAA);
            check("stall_dst", out_dst_idx, 10);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        check("release_a", out_operand_a, 16'hBBBB);
        check("release_dst", out_dst_idx, 11);

        // Flush with held and incoming instruction
        out_ready = 1'b0;
        drive(5'd12, 1'b0, 5'd12, 5'd1, 5'd0, 16'hCCCC, 16'h0303);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_a_hold", out_operand_a, 16'hBBBB);
        flush = 1'b0;

        // Reset during a stall
        drive(5'd13, 1'b0, 5'd13, 5'd1, 5'd0, 16'hDDDD, 16'h0404);
        tick();
        check("pre_rst_valid", out_valid, 1);
        drive(5'd14, 1'b0, 5'd14, 5'd1, 5'd0, 16'hEEEE, 16'h0505);
        tick();
        reset = 1'b1;
        #1;
        check("rst_stall_in_ready", in_ready, 0);
        tick();
        check("rst_stall_valid", out_valid, 0);
        check("rst_stall_a", out_operand_a, 0);
        check("rst_stall_b", out_operand_b, 0);
        check("rst_stall_dst", out_dst_idx, 0);
        check("rst_stall_pc", out_pc, 0);
        check("rst_stall_op", out_op, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_a", out_operand_a, 16'hEEEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_pipe.md
OPERAND_FETCH_PIPE -- requirements
Module: operand_fetch_pipe

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, operand/register data width; IDX_W, default 5, register index width; IMM_W, default 5, immediate width; OP_W, default 5, opcode width; PC_W, default 16, PC width; IMM_SIGNED, default 0, 1 = sign-extend immediate, 0 = zero-extend; ZERO_REG, default 1, 1 = register index 0 always reads 0.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  decode stage presents an instruction.
REQ-005 in_ready  out  1  stage accepts the instruction this cycle.
REQ-006 in_op / in_addr_mode / in_idx_a / in_idx_b / in_imm / in_branch_cond / in_pc / in_has_wb  in  OP_W/1/IDX_W/IDX_W/IMM_W/4/PC_W/1  decoded fields; addr_mode 0 = direct (B from register), 1 = immediate.
REQ-007 rd_idx_a, rd_idx_b  out  IDX_W  register-file read indices, driven combinationally from in_idx_a/in_idx_b.
REQ-008 rd_data_a, rd_data_b  in  DATA_W  register-file read data, same-cycle (asynchronous read).
REQ-009 ex_fwd_valid, ex_fwd_idx, ex_fwd_data  in  1/IDX_W/DATA_W  EX-stage result available for bypass.
REQ-010 ex_busy_valid, ex_busy_idx  in  1/IDX_W  EX holds a writer whose result is not yet available (e.g. load).
REQ-011 wb_fwd_valid, wb_fwd_idx, wb_fwd_data  in  1/IDX_W/DATA_W  write-back result, same cycle as register-file write.
REQ-012 flush  in  1  discard the held and incoming instruction (branch taken).
REQ-013 out_valid  out  1  registered instruction valid to EX.
REQ-014 out_ready  in  1  EX accepts the registered instruction.
REQ-015 out_op, out_operand_a, out_operand_b, out_branch_cond, out_pc, out_has_wb, out_dst_idx  out  OP_W/DATA_W/DATA_W/4/PC_W/1/IDX_W  registered fields; out_dst_idx = in_idx_a captured.

Function
REQ-016 Latency SHALL be exactly 1 cycle from acceptance (in_valid & in_ready at edge) to out_valid.
REQ-017 Source A SHALL always be used; source B SHALL be used only when in_addr_mode = 0.
REQ-018 Per used source, value priority SHALL be: ZERO_REG and idx=0 -> 0; ex_fwd_valid & idx match -> ex_fwd_data; wb_fwd_valid & idx match -> wb_fwd_data; else rd_data.
REQ-019 Immediate mode: out_operand_b SHALL be in_imm extended to DATA_W per IMM_SIGNED (IMM_W < DATA_W required).
REQ-020 Hazard SHALL assert when in_valid, ex_busy_valid, ex_busy_idx matches a used nonzero-or-non-ZERO_REG source, and ex_fwd does not match that source.
REQ-021 in_ready SHALL equal (~out_valid | out_ready) & ~hazard & ~flush, combinationally.
REQ-022 On acceptance all out_* fields SHALL load and out_valid SHALL be 1.
REQ-023 If out_valid & out_ready and no acceptance, out_valid SHALL clear; if out_valid & ~out_ready, all out_* SHALL hold unchanged.
REQ-024 Hazard with EX free SHALL produce a bubble: out_valid = 0 next cycle, operands not updated.
REQ-025 flush SHALL clear out_valid next cycle and block acceptance; flush dominates all other events.
REQ-026 When out_valid = 0, out_* data fields SHALL hold their last value (don't-care to consumer).

Reset
REQ-027 While reset = 1 at an edge, out_valid and all out_* fields SHALL become 0; in_ready SHALL be 0 while reset is high.
REQ-028 Reset mid-stall or mid-transfer SHALL drop the held instruction; first acceptance possible the cycle after reset deasserts.

Verification
REQ-029 Direct ADD idx_a=3 (rf=0x0010), idx_b=4 (rf=0x0020), no fwd -> next cycle out_valid=1, A=0x0010, B=0x0020, dst=3.
REQ-030 Immediate mode, in_imm=5'b11111, IMM_SIGNED=1 -> B=0xFFFF; IMM_SIGNED=0 -> B=0x001F; rd_data_b ignored.
REQ-031 idx_a=7 with ex_fwd(7,0x1111) and wb_fwd(7,0x2222), rf=0x3333 -> A=0x1111; only wb -> 0x2222; idx 0 with ZERO_REG=1 and fwd on idx 0 -> 0.
REQ-032 ex_busy_valid idx=6, instruction reads idx_b=6 direct -> in_ready=0, bubble; same with addr_mode=1 -> no stall.
REQ-033 out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instruction loads next edge.
REQ-034 flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, instruction not accepted; reset asserted during stall -> all outputs 0.
